// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues single-cycle data-memory requests, stalls the
// pipeline while a load/store is outstanding, and hands the result to MEM/WB.
// Misaligned accesses and memory timeouts turn the instruction into a bubble
// and raise a sticky error flag.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid_In,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [15:0] Addr_In,
  input  logic [15:0] WriteData_In,
  input  logic [2:0]  WR_In,
  input  logic        WriteToReg_In,
  input  logic        RegWriteDataSel_In,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] ReadData_ToW,
  output logic [15:0] ALUResult_Out_ToW,
  output logic [2:0]  WR_Out_ToW,
  output logic        WriteToReg_ToW,
  output logic        RegWriteDataSel_Out_ToW,
  output logic        Stall_Out,
  output logic        Err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Last WAIT count at which a missing mem_done becomes an abort.
  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        wr_reg, wr_next;

  logic mem_op;
  logic issue;
  logic misaligned;
  logic complete;
  logic abort;

  assign mem_op = Valid_In & (MemRead_In | MemWrite_In);

  // Next-state logic: issue/misalign decisions in IDLE, completion/timeout in WAIT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wr_next    = wr_reg;
    issue      = 1'b0;
    misaligned = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_op) begin
          if (Addr_In[0]) begin
            misaligned = 1'b1;
            err_next   = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = S_WAIT;
            cnt_next   = 4'd0;
            addr_next  = Addr_In;
            wdata_next = WriteData_In;
            wr_next    = MemWrite_In;
          end
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end else if (cnt_reg == LAST_CNT) begin
          abort      = 1'b1;
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, timeout counter, sticky error and captured request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      addr_reg  <= 16'h0000;
      wdata_reg <= 16'h0000;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wr_reg    <= wr_next;
    end
  end

  // Memory-side outputs: live inputs in the request cycle, captured copy while waiting.
  assign mem_req   = rst & issue;
  assign mem_wr    = rst & (issue ? MemWrite_In : ((state_reg == S_WAIT) & wr_reg));
  assign mem_addr  = issue ? Addr_In : addr_reg;
  assign mem_wdata = issue ? WriteData_In : wdata_reg;

  // Pipeline-side outputs; reset releases the stall immediately.
  assign Stall_Out = rst & mem_op & ~complete & ~abort & ~misaligned;

  assign WriteToReg_ToW = Valid_In & WriteToReg_In & ~Stall_Out & ~abort & ~misaligned
                        & ~(complete & MemWrite_In);

  assign ReadData_ToW            = (complete & Valid_In & MemRead_In) ? mem_rdata : 16'h0000;
  assign ALUResult_Out_ToW       = Addr_In;
  assign WR_Out_ToW              = WR_In;
  assign RegWriteDataSel_Out_ToW = RegWriteDataSel_In;
  assign Err                     = err_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver issues directed and random
// instructions and queues the expected outcome; a monitor compares at each
// memory request and at each hand-off to MEM/WB.
module tb_mem_stage_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Valid_In = 1'b0, MemRead_In = 1'b0, MemWrite_In = 1'b0;
  logic [15:0] Addr_In = '0, WriteData_In = '0;
  logic [2:0]  WR_In = '0;
  logic        WriteToReg_In = 1'b0, RegWriteDataSel_In = 1'b0;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [15:0] ReadData_ToW, ALUResult_Out_ToW;
  logic [2:0]  WR_Out_ToW;
  logic        WriteToReg_ToW, RegWriteDataSel_Out_ToW, Stall_Out, Err;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Valid_In(Valid_In), .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .Addr_In(Addr_In), .WriteData_In(WriteData_In), .WR_In(WR_In),
    .WriteToReg_In(WriteToReg_In), .RegWriteDataSel_In(RegWriteDataSel_In),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ReadData_ToW(ReadData_ToW), .ALUResult_Out_ToW(ALUResult_Out_ToW),
    .WR_Out_ToW(WR_Out_ToW), .WriteToReg_ToW(WriteToReg_ToW),
    .RegWriteDataSel_Out_ToW(RegWriteDataSel_Out_ToW),
    .Stall_Out(Stall_Out), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    int          kind;     // 0 non-mem, 1 load, 2 store
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  wr;
    logic        wtr;
    logic        sel;
    int          n;        // cycles from request to mem_done; 0 = never
    logic [15:0] rdata;
    logic        done0;    // pulse mem_done in the request cycle (must be ignored)
  } instr_t;

  typedef struct {
    logic        wtr;
    logic [15:0] rdata;
    logic [15:0] alu;
    logic [2:0]  wr;
    logic        sel;
    int          stall;
    int          reqs;
  } cmp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  cmp_t cmp_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   errors = 0;
  logic model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks each request pulse and each hand-off to MEM/WB.
  int          stall_cnt = 0;
  int          req_cnt = 0;
  logic [15:0] last_addr = '0;
  req_t        mon_r;
  cmp_t        mon_c;
  always @(negedge clk) begin
    if (!rst) begin
      stall_cnt = 0;
      req_cnt   = 0;
    end else begin
      if (mem_req) begin
        req_cnt++;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_req: got mem_req=1 addr=%0h expected no request", mem_addr);
        end else begin
          mon_r = req_q.pop_front();
          check("req_wr", 32'(mem_wr), 32'(mon_r.wr));
          check("req_addr", 32'(mem_addr), 32'(mon_r.addr));
          if (mon_r.wr) check("req_wdata", 32'(mem_wdata), 32'(mon_r.wdata));
          last_addr = mon_r.addr;
        end
      end else if (Stall_Out) begin
        check("hold_addr", 32'(mem_addr), 32'(last_addr));
      end
      if (Stall_Out) begin
        stall_cnt++;
        check("wtr_in_stall", 32'(WriteToReg_ToW), 32'd0);
      end else if (Valid_In) begin
        if (cmp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handoff: got hand-off alu=%0h expected none", ALUResult_Out_ToW);
        end else begin
          mon_c = cmp_q.pop_front();
          check("wtr", 32'(WriteToReg_ToW), 32'(mon_c.wtr));
          check("rdata", 32'(ReadData_ToW), 32'(mon_c.rdata));
          check("alu", 32'(ALUResult_Out_ToW), 32'(mon_c.alu));
          check("wr_out", 32'(WR_Out_ToW), 32'(mon_c.wr));
          check("sel_out", 32'(RegWriteDataSel_Out_ToW), 32'(mon_c.sel));
          check("stall_cycles", 32'(stall_cnt), 32'(mon_c.stall));
          check("req_count", 32'(req_cnt), 32'(mon_c.reqs));
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end
    end
  end

  function automatic instr_t mk(input logic valid, input int kind, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [2:0] wr, input logic wtr,
                                input logic sel, input int n, input logic [15:0] rdata);
    instr_t t;
    t.valid = valid; t.kind = kind; t.addr = addr; t.wdata = wdata; t.wr = wr;
    t.wtr = wtr; t.sel = sel; t.n = n; t.rdata = rdata; t.done0 = 1'b0;
    return t;
  endfunction

  // Driver: queue expectations from the instruction's rules, then play it out.
  task automatic run(input instr_t t);
    logic mem, aligned, ok, exp_err;
    cmp_t c;
    req_t r;
    int   cyc;
    bit   hit;
    mem     = t.valid && (t.kind != 0);
    aligned = ~t.addr[0];
    ok      = mem && aligned && (t.n >= 1) && (t.n <= TO);
    exp_err = model_err | (mem & (~aligned | ~ok));
    if (mem && aligned) begin
      r.wr = (t.kind == 2); r.addr = t.addr; r.wdata = t.wdata;
      req_q.push_back(r);
    end
    if (t.valid) begin
      c.wtr   = t.wtr & ~(mem & (~ok | (t.kind == 2)));
      c.rdata = (ok && t.kind == 1) ? t.rdata : 16'h0000;
      c.alu   = t.addr;
      c.wr    = t.wr;
      c.sel   = t.sel;
      c.stall = (mem && aligned) ? (ok ? t.n : TO) : 0;
      c.reqs  = (mem && aligned) ? 1 : 0;
      cmp_q.push_back(c);
    end
    Valid_In = t.valid; MemRead_In = (t.kind == 1); MemWrite_In = (t.kind == 2);
    Addr_In = t.addr; WriteData_In = t.wdata; WR_In = t.wr;
    WriteToReg_In = t.wtr; RegWriteDataSel_In = t.sel;
    cyc = 0;
    hit = 0;
    while (cyc < 64) begin
      if (cyc == 0) begin
        mem_done  = t.done0 | (!mem & 1'($urandom_range(0, 1)));
        mem_rdata = 16'($urandom);
      end else begin
        mem_done  = mem && aligned && (cyc == t.n);
        mem_rdata = mem_done ? t.rdata : 16'($urandom);
      end
      @(negedge clk);
      if (!Stall_Out) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got stall after 64 cycles expected release");
    end
    @(posedge clk);
    #1;
    mem_done  = 1'b0;
    Valid_In  = 1'b0;
    model_err = exp_err;
    check("err", 32'(Err), 32'(model_err));
  endtask

  instr_t t;
  int     k, rr;

  initial begin
    // Reset state, including a load presented while reset is held.
    Valid_In = 1'b1; MemRead_In = 1'b1; Addr_In = 16'h0040; WriteToReg_In = 1'b1;
    #2;
    check("rst_err", 32'(Err), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(Stall_Out), 32'd0);
    check("rst_rdata", 32'(ReadData_ToW), 32'd0);
    Valid_In = 1'b0; MemRead_In = 1'b0; WriteToReg_In = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Directed cases: pass-through, load, store, misaligned, timeout, back-to-back.
    run(mk(1'b1, 1, 16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1, 16'h1111));
    run(mk(1'b1, 0, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 0, 16'h0000));
    run(mk(1'b1, 1, 16'h0040, 16'h0000, 3'd2, 1'b1, 1'b1, 3, 16'hBEEF));
    run(mk(1'b1, 2, 16'h0010, 16'h00FF, 3'd1, 1'b1, 1'b0, 1, 16'h0000));
    run(mk(1'b1, 1, 16'h0021, 16'h0000, 3'd4, 1'b1, 1'b1, 2, 16'h5555));
    run(mk(1'b1, 1, 16'h0030, 16'h0000, 3'd6, 1'b1, 1'b1, 2, 16'hA5A5));
    run(mk(1'b1, 1, 16'h0050, 16'h0000, 3'd7, 1'b1, 1'b1, 0, 16'h0000));
    run(mk(1'b1, 1, 16'h0052, 16'h0000, 3'd7, 1'b1, 1'b1, TO, 16'h7777));
    run(mk(1'b1, 1, 16'h0054, 16'h0000, 3'd3, 1'b1, 1'b1, 2, 16'hCAFE));

    // Randomized mix.
    for (k = 0; k < 60; k++) begin
      t.valid = ($urandom_range(0, 7) != 0);
      t.kind  = $urandom_range(0, 2);
      t.addr  = 16'($urandom);
      t.addr[0] = ($urandom_range(0, 5) == 0);
      t.wdata = 16'($urandom);
      t.wr    = 3'($urandom);
      t.wtr   = 1'($urandom);
      t.sel   = 1'($urandom);
      rr      = $urandom_range(0, 9);
      t.n     = (rr == 0) ? 0 : (rr == 1) ? TO : $urandom_range(1, 4);
      t.rdata = 16'($urandom);
      t.done0 = 1'b0;
      run(t);
    end

    // Reset mid-WAIT: everything drops at once, a late mem_done is ignored.
    t = mk(1'b1, 1, 16'h0080, 16'h0000, 3'd2, 1'b1, 1'b0, 0, 16'h0000);
    t.kind = 1;
    begin
      req_t r;
      r.wr = 1'b0; r.addr = 16'h0080; r.wdata = 16'h0000;
      req_q.push_back(r);
    end
    Valid_In = 1'b1; MemRead_In = 1'b1; MemWrite_In = 1'b0;
    Addr_In = 16'h0080; WR_In = 3'd2; WriteToReg_In = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_stall", 32'(Stall_Out), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(Stall_Out), 32'd0);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_err", 32'(Err), 32'd0);
    model_err = 1'b0;
    Valid_In = 1'b0; MemRead_In = 1'b0; WriteToReg_In = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Second cycle after release: mem_done pulse in IDLE alongside a new load.
    t = mk(1'b1, 1, 16'h0090, 16'h0000, 3'd1, 1'b1, 1'b1, 2, 16'h4321);
    t.done0 = 1'b1;
    run(t);
    run(mk(1'b1, 0, 16'h00AA, 16'h0000, 3'd6, 1'b1, 1'b0, 0, 16'h0000));

    check("cmp_q_empty", 32'(cmp_q.size()), 32'd0);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
